// File: rtl/nibble_adder_pkg.sv
// ============================================================================
// nibble_adder_pkg -- shared types and constants for the nibble-serial adder.
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ripple_adder_4.sv
// ============================================================================
// ripple_adder_4 -- combinational 4-bit adder with carry-in and 5-bit result.
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module ripple_adder_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [4:0] sum
);

  logic [4:0] carry;

  always_comb begin
    carry[0] = ci;
    for (int i = 0; i < 4; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    sum[4] = carry[4];
  end

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// nibble_serial_adder -- W-bit adder that processes one nibble per clock.
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          ci,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES:0]     sum
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e           state_q,     state_d;
  logic [W-1:0]     a_q,         a_d;
  logic [W-1:0]     b_q,         b_d;
  logic             carry_q,     carry_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [W:0]       sum_q,       sum_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W:0]   nib_sum;

  always_comb begin
    nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];
  end

  ripple_adder_4 u_nibble_add (
    .a   (nib_a),
    .b   (nib_b),
    .ci  (carry_q),
    .sum (nib_sum)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = nib_sum[NIBBLE_W-1:0];
        carry_d = nib_sum[NIBBLE_W];
        // idx parks on the last nibble rather than wrapping
        if (idx_q == LAST_IDX) begin
          sum_d[W] = nib_sum[NIBBLE_W];
          state_d  = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// tb_nibble_serial_adder -- directed self-checking bench for nibble_serial_adder.
// Rev 1.0 -- initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] sum;

  int tests_run;
  int tests_failed;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Accept one operand set, verify the 4-cycle latency and result, then handshake.
  task automatic do_add(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                        input logic op_ci, input logic [16:0] expected);
    a = op_a; b = op_b; ci = op_ci; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
    for (int c = 1; c < 4; c++) begin
      tick();
      check({tag, ".no_early_valid"}, {31'd0, out_valid}, 32'd0);
    end
    tick();
    check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".sum"}, {15'd0, sum}, {15'd0, expected});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".idle_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, ".sum_retained"}, {15'd0, sum}, {15'd0, expected});
  endtask

  logic [15:0] ops_a  [3];
  logic [15:0] ops_b  [3];
  logic        ops_ci [3];
  logic [16:0] ops_exp[3];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    check("reset.in_ready", {31'd0, in_ready}, 32'd1);
    check("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check("reset.sum", {15'd0, sum}, 32'd0);
    tick();
    check("idle.sum_zero", {15'd0, sum}, 32'd0);

    do_add("add_carry_out", 16'h0001, 16'hFFFF, 1'b0, 17'h10000);
    do_add("add_all_ones",  16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
    do_add("add_nib_carry", 16'h000F, 16'h0001, 1'b0, 17'h00010);

    // Back-pressure: hold the result for 10 cycles while inputs wiggle.
    a = 16'h1234; b = 16'h4321; ci = 1'b0; in_valid = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
      tick();
    end
    for (int c = 0; c < 10; c++) begin
      check("bp.out_valid", {31'd0, out_valid}, 32'd1);
      check("bp.sum", {15'd0, sum}, 32'h05555);
      check("bp.in_ready", {31'd0, in_ready}, 32'd0);
      a = 16'($urandom); b = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.release_valid", {31'd0, out_valid}, 32'd0);
    check("bp.release_ready", {31'd0, in_ready}, 32'd1);
    check("bp.release_sum", {15'd0, sum}, 32'h05555);

    // Reset in the second RUN cycle aborts silently.
    a = 16'hAAAA; b = 16'h5555; ci = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort.in_ready", {31'd0, in_ready}, 32'd1);
    check("abort.sum", {15'd0, sum}, 32'd0);
    for (int c = 0; c < 6; c++) begin
      check("abort.no_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    do_add("after_abort", 16'h0003, 16'h0004, 1'b0, 17'h00007);

    // Back-to-back with in_valid held high and operands scrambled during RUN.
    ops_a[0] = 16'h1111; ops_b[0] = 16'h2222; ops_ci[0] = 1'b1; ops_exp[0] = 17'h03334;
    ops_a[1] = 16'h8000; ops_b[1] = 16'h8000; ops_ci[1] = 1'b0; ops_exp[1] = 17'h10000;
    ops_a[2] = 16'h0FF0; ops_b[2] = 16'h0010; ops_ci[2] = 1'b1; ops_exp[2] = 17'h01001;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = ops_a[k]; b = ops_b[k]; ci = ops_ci[k];
      tick();
      check("b2b.accepted", {31'd0, in_ready}, 32'd0);
      for (int c = 1; c < 4; c++) begin
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
        tick();
        check("b2b.no_early_valid", {31'd0, out_valid}, 32'd0);
      end
      if (k < 2) begin
        a = ops_a[k+1]; b = ops_b[k+1]; ci = ops_ci[k+1];
      end
      tick();
      check("b2b.out_valid", {31'd0, out_valid}, 32'd1);
      check("b2b.sum", {15'd0, sum}, {15'd0, ops_exp[k]});
      tick();
      check("b2b.idle_gap_valid", {31'd0, out_valid}, 32'd0);
      check("b2b.idle_gap_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    check("b2b.final_idle", {31'd0, in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
